// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count, thresholds, sticky errors and flush
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   w_en,
    input  logic                   r_en,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AF = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] C_AE = (AW+1)'(AE_LEVEL);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_acc, rd_acc;
    assign wr_acc = w_en & (~full | r_en);
    assign rd_acc = r_en & ~empty;
    assign empty = count == '0;
    assign full = count == C_FULL;
    assign almost_empty = count <= C_AE;
    assign almost_full = count >= C_AF;
    // storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (nrst && !flush && wr_acc) mem[wr_ptr] <= data_in;
    end
    // pointers and occupancy; flush clears them like reset
    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc & ~rd_acc) count <= count + (AW+1)'(1);
            else if (rd_acc & ~wr_acc) count <= count - (AW+1)'(1);
        end
    end
    // registered read port; data_out holds when nothing is read
    always_ff @(posedge clk) begin
        if (!nrst) begin
            data_out <= '0;
            valid <= 1'b0;
        end else begin
            valid <= rd_acc & ~flush;
            if (rd_acc & ~flush) data_out <= mem[rd_ptr];
        end
    end
    // sticky error flags; a new error beats err_clr, flush never sets them
    always_ff @(posedge clk) begin
        if (!nrst) begin
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow <= (~flush & w_en & ~wr_acc) | (overflow & ~err_clr);
            underflow <= (~flush & r_en & ~rd_acc) | (underflow & ~err_clr);
        end
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: scoreboard bench for fifo_sync_param (8x8, AF=6, AE=2)
module tb_fifo_sync_param;
    localparam int D = 8;
    logic clk = 1'b0, nrst = 1'b0, flush = 1'b0, w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
    logic [7:0] data_in = 8'h00, data_out;
    logic valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [3:0] count;
    int checks = 0, errors = 0, n_recv = 0;
    logic [7:0] model[$], exp_q[$];
    logic exp_valid = 1'b0, m_ovf = 1'b0, m_und = 1'b0, mon_en = 1'b0;
    logic [7:0] m_dout = 8'h00, sb_e;

    fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .nrst(nrst), .flush(flush), .data_in(data_in), .w_en(w_en), .r_en(r_en),
        .err_clr(err_clr), .data_out(data_out), .valid(valid), .count(count), .empty(empty),
        .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // scoreboard: every DUT read result is compared with the next expected word
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (valid !== exp_valid) begin
                errors++;
                $display("FAIL sb_valid: got %b expected %b at %0t", valid, exp_valid, $time);
            end else if (valid) begin
                n_recv++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected nothing at %0t", data_out, $time);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (data_out !== sb_e) begin
                        errors++;
                        $display("FAIL sb_data: got %h expected %h at %0t", data_out, sb_e, $time);
                    end
                end
            end else if (data_out !== m_dout) begin
                errors++;
                $display("FAIL sb_hold: got %h expected %h at %0t", data_out, m_dout, $time);
            end
        end
    end

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic fl, input logic ec);
        logic wacc, racc, nov, nun;
        logic [7:0] nd;
        int mc;
        nd = m_dout;
        mc = model.size();
        wacc = !fl && w && (mc < D || r);
        racc = !fl && r && mc > 0;
        nov = (!fl && w && !wacc) || (m_ovf && !ec);
        nun = (!fl && r && !racc) || (m_und && !ec);
        if (racc) begin
            nd = model.pop_front();
            exp_q.push_back(nd);
        end
        if (wacc) model.push_back(d);
        if (fl) model.delete();
        w_en = w; r_en = r; data_in = d; flush = fl; err_clr = ec;
        @(posedge clk);
        #1;
        exp_valid = racc;
        m_dout = nd;
        m_ovf = nov;
        m_und = nun;
    endtask

    task automatic apply_reset();
        nrst = 1'b0; w_en = 1'b0; r_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        #1;
        model.delete(); exp_q.delete();
        exp_valid = 1'b0; m_dout = 8'h00; m_ovf = 1'b0; m_und = 1'b0;
        nrst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", almost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", overflow, underflow); end
        checks++; if (valid !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %b/%h expected 0/00", valid, data_out); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(16 + i), 1'b0, 1'b0);
            checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1); end
            checks++; if (almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_ae: got %b at count %0d", almost_empty, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af: got %b at count %0d", almost_full, i + 1); end
            checks++; if (full !== (i + 1 == 8)) begin errors++; $display("FAIL fill_full: got %b at count %0d", full, i + 1); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf: got %b expected 0", overflow); end
        end
    endtask

    task automatic test_overflow_drain();
        step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            checks++; if (valid !== 1'b1 || data_out !== 8'(16 + i)) begin errors++; $display("FAIL drain_data: got %b/%h expected 1/%h", valid, data_out, 8'(16 + i)); end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL drain_empty: got %b/%0d expected 1/0", empty, count); end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL und_set: got %b expected 1", underflow); end
        checks++; if (valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL und_state: got %b/%0d expected 0/0", valid, count); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL und_clr: got %b expected 0", underflow); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(32 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        checks++; if (count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL full_rw: got count %0d ovf %b expected 8/0", count, overflow); end
        checks++; if (valid !== 1'b1 || data_out !== 8'h20) begin errors++; $display("FAIL full_rw_data: got %b/%h expected 1/20", valid, data_out); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            checks++; if (data_out !== ((i < 7) ? 8'(33 + i) : 8'h55)) begin errors++; $display("FAIL full_rw_order: got %h at read %0d", data_out, i); end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        int maxc, base;
        maxc = 0;
        base = n_recv;
        step(1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
        maxc = int'(count);
        for (int i = 1; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(64 + i), 1'b0, 1'b0);
            if (int'(count) > maxc) maxc = int'(count);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (data_out !== 8'h53) begin errors++; $display("FAIL b2b_last: got %h expected 53", data_out); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (maxc > 2) begin errors++; $display("FAIL b2b_maxcount: got %0d expected <=2", maxc); end
        checks++; if (n_recv - base != 20 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_recv: got %0d words expected 20", n_recv - base); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(96 + i), 1'b0, 1'b0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", count); end
        step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear: got %0d/%b expected 0/1", count, empty); end
        checks++; if (valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL flush_flags: got %b/%b expected 0/0", valid, overflow); end
        checks++; if (data_out !== 8'h53) begin errors++; $display("FAIL flush_hold: got %h expected 53", data_out); end
        step(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (valid !== 1'b1 || data_out !== 8'h3C) begin errors++; $display("FAIL flush_after: got %b/%h expected 1/3c", valid, data_out); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_end: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(112 + i), 1'b0, 1'b0);
        apply_reset();
        checks++; if (count !== 4'd0 || data_out !== 8'h00) begin errors++; $display("FAIL midrst_state: got %0d/%h expected 0/00", count, data_out); end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (underflow !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL midrst_read: got und %b valid %b expected 1/0", underflow, valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_full_rw();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO that replaces the fixed 8x8 synchronous FIFO.
- Configurable data width and depth.
- Guards against overflow and underflow, with sticky error flags.
- Exposes an occupancy count and programmable almost-full / almost-empty thresholds.
- Supports a synchronous flush.

It sits between same-clock producer and consumer datapaths as a general rate-smoothing buffer.

Parameters:
- WIDTH, 8: data word width in bits, >= 1.
- DEPTH, 8: number of entries. Must be a power of two, >= 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- nrst  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear of FIFO contents.
- data_in  in  WIDTH  write data.
- w_en  in  1  write request.
- r_en  in  1  read request.
- err_clr  in  1  clears the sticky overflow/underflow flags.
- data_out  out  WIDTH  registered read data.
- valid  out  1  data_out holds a newly read word this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (nrst low at a clk edge):
  - wr_ptr, rd_ptr and count go to 0; data_out=0; valid=0; overflow=0; underflow=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - RAM contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by the explicit count register, never by pointer compare.
- Write acceptance: wr_acc = w_en & (~full | r_en).
  - When full, a simultaneous read frees the slot and both are accepted.
  - An accepted write stores data_in at wr_ptr and increments wr_ptr.
- Read acceptance: rd_acc = r_en & ~empty.
  - When empty, a simultaneous write is accepted but the read is rejected. There is no fall-through.
  - An accepted read increments rd_ptr.
  - On the next edge, data_out takes RAM[rd_ptr] (one-cycle read latency) and valid=1 for exactly that cycle.
- No accepted read: valid=0 and data_out holds its last value.
- count next value:
  - +1 if wr_acc & ~rd_acc.
  - -1 if rd_acc & ~wr_acc.
  - unchanged otherwise.
  - count never exceeds DEPTH and never goes below 0.
- Status flags (empty, full, almost_empty, almost_full) are combinational decodes of the registered count, so they reflect post-edge state.
- overflow is set on w_en & ~wr_acc. underflow is set on r_en & ~rd_acc.
  - Both stay set until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- flush (priority over w_en/r_en in the same cycle):
  - Next edge: pointers and count go to 0, valid=0.
  - data_out holds its value; error flags are unaffected.
  - w_en/r_en during flush are ignored and do not set error flags.
- Priority order: nrst > flush > normal operation.
- Reset asserted mid-stream: all in-flight data is discarded; the first read after release sees an empty FIFO.

Test Plan (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
1. Reset, then write 0x10..0x17 on 8 consecutive cycles.
   -> count steps 1..8; almost_empty drops when count=3; almost_full rises at count=6; full=1 at count=8; overflow=0.
2. From full, a 9th write of 0xAA alone -> rejected, overflow=1, count stays 8. Then read 8 times -> data_out 0x10..0x17, each with valid=1 one cycle after its r_en; 0xAA never appears; empty=1 at the end.
3. Empty FIFO, r_en=1 -> underflow=1, valid=0, count=0. Pulse err_clr -> underflow=0 on the next edge.
4. Full FIFO, w_en=r_en=1 with data_in=0x55 -> both accepted, count stays 8, no overflow. After 8 further reads, 0x55 appears last.
5. Write 20 words while reading continuously with 1-cycle lag -> pointers wrap twice; output order equals input order; count never exceeds 2.
6. Hold 5 words, then assert flush together with w_en=1 -> count=0, empty=1, valid=0, no overflow; the next write/read pair returns the new word only.
